// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - PWM capture pin input and measurement report bundle
interface pwm_capture_if #(
    parameter int CTR_LEN = 8
);
    logic               pwm_in;
    logic [CTR_LEN:0]   period;
    logic [CTR_LEN:0]   high_time;
    logic               valid;
    logic               static_flag;
    logic               static_lvl;

    modport master (
        input  pwm_in,
        output period,
        output high_time,
        output valid,
        output static_flag,
        output static_lvl
    );

    modport slave (
        output pwm_in,
        input  period,
        input  high_time,
        input  valid,
        input  static_flag,
        input  static_lvl
    );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture with static-line timeout
// Optional glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
    parameter int CTR_LEN = 8
) (
    input  logic            clk,
    input  logic            rst,
    pwm_capture_if.master   bus
);
    localparam int W = CTR_LEN + 1;
    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic {ARM, MEAS} state_t;

    state_t         state, state_nx;
    logic           sync1, sync2;
    logic           pwm_s, pwm_d, rise;
    logic [W-1:0]   pcnt, hcnt;
    logic           rpt_norm, rpt_tout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic hist1, hist2, held;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist1 <= 1'b0;
            hist2 <= 1'b0;
            held  <= 1'b0;
        end else begin
            hist1 <= sync2;
            hist2 <= hist1;
            held  <= pwm_s;
        end
    end

    // Level only moves once three consecutive synchronized samples agree.
    assign pwm_s = (sync2 == hist1 && hist1 == hist2) ? sync2 : held;
`else
    assign pwm_s = sync2;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pwm_d <= 1'b0;
        else      pwm_d <= pwm_s;
    end

    assign rise = pwm_s & ~pwm_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ARM;
        else      state <= state_nx;
    end

    // A rise always beats a simultaneous timeout.
    always_comb begin
        state_nx = state;
        rpt_norm = 1'b0;
        rpt_tout = 1'b0;
        case (state)
            ARM: begin
                if (rise)             state_nx = MEAS;
                else if (pcnt == MAX) rpt_tout = 1'b1;
            end
            MEAS: begin
                if (rise) begin
                    rpt_norm = 1'b1;
                end else if (pcnt == MAX) begin
                    rpt_tout = 1'b1;
                    state_nx = ARM;
                end
            end
            default: state_nx = ARM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
            hcnt <= '0;
        end else if (rise) begin
            pcnt <= ONE;
            hcnt <= ONE;
        end else if (rpt_tout) begin
            pcnt <= '0;
            hcnt <= '0;
        end else begin
            pcnt <= (pcnt == MAX) ? MAX : pcnt + ONE;
            hcnt <= (hcnt == MAX) ? MAX : hcnt + {{(W-1){1'b0}}, pwm_s};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.period      <= '0;
            bus.high_time   <= '0;
            bus.valid       <= 1'b0;
            bus.static_flag <= 1'b0;
            bus.static_lvl  <= 1'b0;
        end else begin
            bus.valid <= rpt_norm | rpt_tout;
            if (rpt_norm) begin
                bus.period      <= pcnt;
                bus.high_time   <= hcnt;
                bus.static_flag <= 1'b0;
            end else if (rpt_tout) begin
                bus.period      <= '0;
                bus.high_time   <= '0;
                bus.static_flag <= 1'b1;
                bus.static_lvl  <= pwm_s;
            end
        end
    end
endmodule
